// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the programmable serial sequence detector.
package seq_detect_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/seq_match_core.sv
// Shift-and-compare engine: serial history, fill counter and length-masked pattern compare.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift_en,
  input  logic          clear,
  input  logic          fill_clr,
  input  logic          seq,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len,
  output logic          match
);

  logic [W-1:0]  hist_reg;
  logic [W-1:0]  hist_next;
  logic [W-1:0]  mask;
  logic [LW-1:0] fill_reg;
  logic [LW-1:0] fill_next;

  assign hist_next = {hist_reg[W-2:0], seq};
  assign fill_next = (fill_reg == LW'(W)) ? fill_reg : fill_reg + 1'b1;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_mask
      assign mask[gi] = (len > LW'(gi));
    end
  endgenerate

  // Evaluated on the post-shift view so the completing bit is reported at its own edge.
  assign match = shift_en && (fill_next >= len) &&
                 ((hist_next & mask) == (pattern & mask));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (clear) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (shift_en) begin
      hist_reg <= hist_next;
      fill_reg <= fill_clr ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Controller: config handshake, ARMED/RUN sequencing, match counting and done signalling.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LW    = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [W-1:0]     cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  output logic             cfg_err,
  input  logic             start,
  input  logic             abort,
  input  logic             seq,
  output logic             detected,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] match_count
);

  state_t           state_reg, state_next;
  logic [W-1:0]     pattern_reg, pattern_next;
  logic [LW-1:0]    len_reg, len_next;
  logic             overlap_reg, overlap_next;
  logic [CNT_W-1:0] target_reg, target_next;
  logic [CNT_W-1:0] count_reg, count_next, count_inc;
  logic             detected_reg, detected_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             shift_en, clear, fill_clr, match;

  seq_match_core #(.W(W), .LW(LW)) u_core (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clear    (clear),
    .fill_clr (fill_clr),
    .seq      (seq),
    .pattern  (pattern_reg),
    .len      (len_reg),
    .match    (match)
  );

  assign count_inc = (count_reg == '1) ? count_reg : count_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    pattern_next  = pattern_reg;
    len_next      = len_reg;
    overlap_next  = overlap_reg;
    target_next   = target_reg;
    count_next    = count_reg;
    detected_next = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;
    shift_en      = 1'b0;
    clear         = 1'b0;
    fill_clr      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_len >= LW'(1) && cfg_len <= LW'(W)) begin
            pattern_next = cfg_pattern;
            len_next     = cfg_len;
            overlap_next = cfg_overlap;
            target_next  = cfg_target;
            state_next   = ARMED;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ARMED: begin
        if (abort) begin
          pattern_next = '0;
          len_next     = '0;
          overlap_next = 1'b0;
          target_next  = '0;
          state_next   = IDLE;
        end else if (start) begin
          clear      = 1'b1;
          count_next = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          pattern_next = '0;
          len_next     = '0;
          overlap_next = 1'b0;
          target_next  = '0;
          state_next   = IDLE;
        end else begin
          shift_en = 1'b1;
          if (match) begin
            detected_next = 1'b1;
            count_next    = count_inc;
            fill_clr      = !overlap_reg;
            if (target_reg != '0 && count_inc == target_reg) begin
              done_next  = 1'b1;
              state_next = ARMED;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pattern_reg  <= '0;
      len_reg      <= '0;
      overlap_reg  <= 1'b0;
      target_reg   <= '0;
      count_reg    <= '0;
      detected_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pattern_reg  <= pattern_next;
      len_reg      <= len_next;
      overlap_reg  <= overlap_next;
      target_reg   <= target_next;
      count_reg    <= count_next;
      detected_reg <= detected_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign cfg_ready   = (state_reg == IDLE);
  assign busy        = (state_reg == RUN);
  assign detected    = detected_reg;
  assign done        = done_reg;
  assign cfg_err     = err_reg;
  assign match_count = count_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl (W=8, CNT_W=2).
module tb_seq_detect_ctrl;

  localparam int W     = 8;
  localparam int CNT_W = 2;
  localparam int LW    = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [W-1:0]     cfg_pattern = '0;
  logic [LW-1:0]    cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             cfg_err;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             seq = 1'b0;
  logic             detected;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] match_count;

  int total = 0;
  int passed = 0;

  seq_detect_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .cfg_err     (cfg_err),
    .start       (start),
    .abort       (abort),
    .seq         (seq),
    .detected    (detected),
    .done        (done),
    .busy        (busy),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic configure(input logic [W-1:0] p, input logic [LW-1:0] l,
                           input logic ov, input logic [CNT_W-1:0] t);
    cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_target = t; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Feeds n bits (LSB of stream first) and checks detected/done after each sample edge.
  task automatic run_stream(input string tag, input int n, input logic [15:0] bits,
                            input logic [15:0] det_exp, input logic [15:0] done_exp);
    for (int i = 0; i < n; i++) begin
      seq = bits[i];
      tick();
      chk($sformatf("%s_det%0d", tag, i + 1), 32'(detected), 32'(det_exp[i]));
      chk($sformatf("%s_done%0d", tag, i + 1), 32'(done), 32'(done_exp[i]));
      $display("%s bit%0d seq=%0b detected=%0b done=%0b count=%0d busy=%0b",
               tag, i + 1, bits[i], detected, done, match_count, busy);
    end
    seq = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_detected", 32'(detected), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // start in IDLE is ignored
    do_start();
    chk("idle_start_busy", 32'(busy), 32'd0);
    chk("idle_start_ready", 32'(cfg_ready), 32'd1);

    // 1010, len 4, overlap: matches on bits 4 and 6
    configure(8'b1010, 4'd4, 1'b1, 2'd0);
    chk("t1_ready_low", 32'(cfg_ready), 32'd0);
    chk("t1_armed_busy", 32'(busy), 32'd0);
    do_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_count0", 32'(match_count), 32'd0);
    run_stream("t1", 6, 16'b010101, 16'b101000, 16'b0);
    chk("t1_count", 32'(match_count), 32'd2);
    chk("t1_busy_end", 32'(busy), 32'd1);
    do_abort();
    chk("t1_abort_ready", 32'(cfg_ready), 32'd1);
    chk("t1_abort_busy", 32'(busy), 32'd0);
    chk("t1_abort_count_hold", 32'(match_count), 32'd2);

    // same pattern, no overlap: matches on bits 4 and 8 only
    configure(8'b1010, 4'd4, 1'b0, 2'd0);
    do_start();
    chk("t2_count0", 32'(match_count), 32'd0);
    run_stream("t2", 8, 16'b01010101, 16'b10001000, 16'b0);
    chk("t2_count", 32'(match_count), 32'd2);
    do_abort();

    // 011, len 3, target 2: detected+done on bit 6, back to ARMED
    configure(8'b011, 4'd3, 1'b0, 2'd2);
    do_start();
    run_stream("t3", 6, 16'b110110, 16'b100100, 16'b100000);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_ready", 32'(cfg_ready), 32'd0);
    chk("t3_count", 32'(match_count), 32'd2);
    tick();
    chk("t3_done_pulse", 32'(done), 32'd0);
    chk("t3_count_hold", 32'(match_count), 32'd2);
    do_start();
    chk("t3_restart_count", 32'(match_count), 32'd0);
    chk("t3_restart_busy", 32'(busy), 32'd1);
    do_abort();

    // illegal lengths
    configure(8'hAA, 4'd0, 1'b0, 2'd0);
    chk("t4_len0_err", 32'(cfg_err), 32'd1);
    chk("t4_len0_ready", 32'(cfg_ready), 32'd1);
    tick();
    chk("t4_err_clear", 32'(cfg_err), 32'd0);
    configure(8'hAA, 4'd9, 1'b0, 2'd0);
    chk("t4_len9_err", 32'(cfg_err), 32'd1);
    chk("t4_len9_ready", 32'(cfg_ready), 32'd1);
    configure(8'hAA, 4'd8, 1'b0, 2'd0);
    chk("t4_legal_err", 32'(cfg_err), 32'd0);
    chk("t4_legal_ready", 32'(cfg_ready), 32'd0);

    // start and abort together: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(cfg_ready), 32'd1);
    tick();
    chk("t5_busy_later", 32'(busy), 32'd0);

    // len 1 pattern 1: saturates at 3, detected every bit
    configure(8'b1, 4'd1, 1'b1, 2'd0);
    do_start();
    run_stream("t6", 6, 16'b111111, 16'b111111, 16'b0);
    chk("t6_sat_count", 32'(match_count), 32'd3);
    chk("t6_busy", 32'(busy), 32'd1);

    // asynchronous reset mid-run while detected is high
    seq = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_detected", 32'(detected), 32'd0);
    chk("t7_rst_count", 32'(match_count), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_ready", 32'(cfg_ready), 32'd1);
    $display("t7 async reset detected=%0b count=%0d busy=%0b", detected, match_count, busy);
    seq = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable controller for the serial sequence-detector datapath: accepts a pattern configuration over a valid/ready handshake, then arms, runs and stops a shift-and-compare match engine on a 1-bit serial stream. It counts matches and signals completion after a target count. It sits between the host/config logic and the raw `seq` stream, replacing the fixed-pattern detector wherever pattern, overlap mode or run length must change at runtime.

## Interface
- `W`, 8, maximum pattern length in bits (≥2)
- `CNT_W`, 8, width of match counter and target
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_valid`  in  1  configuration offered
- `cfg_ready`  out  1  controller accepts configuration (high only in IDLE)
- `cfg_pattern`  in  W  pattern; bit [len-1] is the oldest bit, bit 0 the newest
- `cfg_len`  in  $clog2(W+1)  pattern length, legal 1..W
- `cfg_overlap`  in  1  1 = overlapping matches allowed
- `cfg_target`  in  CNT_W  matches before done; 0 = run until abort
- `cfg_err`  out  1  one-cycle pulse: illegal length rejected
- `start`  in  1  begin a run (ARMED only)
- `abort`  in  1  stop and return to IDLE
- `seq`  in  1  serial data, sampled every cycle in RUN
- `detected`  out  1  one-cycle pulse per match
- `done`  out  1  one-cycle pulse when target reached
- `busy`  out  1  high in RUN
- `match_count`  out  CNT_W  matches in current run, saturating

## Operation
- States: IDLE, ARMED, RUN.
- IDLE: `cfg_ready`=1. Handshake on `cfg_valid & cfg_ready`: if `cfg_len` in 1..W, latch pattern/len/overlap/target → ARMED; else pulse `cfg_err`, stay IDLE.
- ARMED: config held. `start` → RUN; history and fill cleared, `match_count` cleared to 0. `cfg_valid` ignored.
- RUN: each cycle shift `seq` into history (newest at bit 0); fill counter increments, saturating at W.
- Match: fill ≥ len and history[len-1:0] == pattern[len-1:0]. On match: `detected` pulse; `match_count`+1, saturating at 2^CNT_W−1.
- Overlap=0: on match, fill resets to 0 so the next match needs len fresh bits. Overlap=1: fill unchanged.
- Target≠0 and post-increment count == target: `done` pulse with that `detected`, state → ARMED (config retained, `match_count` holds until next `start`).
- `abort` in ARMED or RUN → IDLE; config discarded, `match_count` holds. `abort` and `start` in the same cycle: abort wins. `abort` in IDLE: no effect.
- `start` outside ARMED: ignored.

## Timing
- Reset values: state IDLE, `cfg_ready`=1, `cfg_err`=0, `detected`=0, `done`=0, `busy`=0, `match_count`=0, history/fill/config registers 0.
- All outputs registered. The bit completing a match, sampled at edge k, raises `detected` from edge k to k+1; `match_count` updates at the same edge k.
- `start` at edge k: state RUN and `busy`=1 after edge k; first `seq` sample at edge k+1.
- Config accepted at edge k: ARMED after edge k; `cfg_ready` low from edge k.
- `cfg_err` high for exactly the cycle following the rejecting edge.
- `done` at edge k: `busy`=0 after edge k; no `seq` sampled at edge k+1.
- `rst` asserted mid-run: all outputs go to reset values immediately, without waiting for a clock edge; any in-flight `detected`/`done` pulse is lost.

## Structure
- Package `seq_detect_pkg`: state enum (IDLE, ARMED, RUN), default `W`/`CNT_W` constants.
- Sub-module `seq_match_core`: history shift register, fill counter, length-masked compare. It has an inputs `shift_en`, `clear` and `fill_clr` and outputs `match`. The controller owns the FSM, handshake and counter.

## Test plan
- Pattern 4'b1010, len 4, overlap 1, target 0; stream 1,0,1,0,1,0 → `detected` after bits 4 and 6, `match_count`=2, `busy` stays 1.
- Same with overlap 0; stream 1,0,1,0,1,0,1,0 → `detected` after bits 4 and 8 only, count=2.
- Pattern 3'b011, len 3, target 2; stream 0,1,1,0,1,1 → `detected` and `done` together on bit 6, state ARMED, `cfg_ready`=0; a new `start` resets count to 0.
- Config with `cfg_len`=0, then `cfg_len`=W+1 → `cfg_err` pulse each time, state IDLE; next legal config is accepted.
- `start`+`abort` in the same cycle in ARMED → IDLE, `busy` never rises. `rst` mid-RUN after 3 matches → all outputs 0 asynchronously.
- CNT_W=2, pattern 1'b1, len 1, target 0, six 1s → `match_count` saturates at 3, `detected` pulses on every bit.
